// File: rtl/csi_packet_rx.sv
// CSI-2 packet layer: parses headers from the aligned lane word stream, tracks FS/FE,
// and streams long-packet payload out through a first-word-fall-through FIFO as AXI-stream.
module csi_packet_rx #(
  parameter int         N_LANES         = 2,
  parameter int         FIFO_DEPTH      = 16,
  parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_LANES*8-1:0] word_in,
  input  logic                 word_valid,
  output logic                 m_axis_tvalid,
  output logic [N_LANES*8-1:0] m_axis_tdata,
  output logic [N_LANES-1:0]   m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 m_axis_tready,
  output logic                 frame_active,
  output logic [15:0]          line_count,
  output logic                 overflow,
  output logic                 truncated
);
  localparam int W         = N_LANES * 8;
  localparam int HDR_BEATS = 4 / N_LANES;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;
  localparam int EW        = W + N_LANES + 2;

  typedef enum logic [1:0] {HDR, PAYLOAD, WAIT_EOT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    hdr_cnt_q, hdr_cnt_d;
  logic [31:0]   hdr_q, hdr_d, hdr_full;
  logic [15:0]   rem_q, rem_d;
  logic          sof_q, sof_d;
  logic          active_d, trunc_d;
  logic [15:0]   line_d;
  logic [5:0]    dt;
  logic [15:0]   wc;

  logic               wr_d, wr_last_d, wr_user_d;
  logic [N_LANES-1:0] wr_keep_d;
  logic               wr_q;
  logic [EW-1:0]      wr_entry_q;

  // Header as it looks including the beat on the wire this cycle.
  always_comb begin
    hdr_full = hdr_q;
    for (int b = 0; b < HDR_BEATS; b++)
      if (hdr_cnt_q == 2'(b)) hdr_full[b*W +: W] = word_in;
  end

  assign dt = hdr_full[5:0];
  assign wc = hdr_full[23:8];

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    hdr_d     = hdr_q;
    rem_d     = rem_q;
    sof_d     = sof_q;
    active_d  = frame_active;
    line_d    = line_count;
    trunc_d   = truncated;
    wr_d      = 1'b0;
    wr_keep_d = '1;
    wr_last_d = 1'b0;
    wr_user_d = 1'b0;
    case (state_q)
      HDR: begin
        if (!word_valid) begin
          hdr_cnt_d = 2'd0;
        end else if (hdr_cnt_q == 2'(HDR_BEATS - 1)) begin
          hdr_cnt_d = 2'd0;
          state_d   = WAIT_EOT;
          if (hdr_full[7:6] == VIRTUAL_CHANNEL) begin
            if (dt == 6'h00) begin
              active_d = 1'b1;
              line_d   = 16'd0;
              sof_d    = 1'b1;
            end else if (dt == 6'h01) begin
              active_d = 1'b0;
            end else if (dt >= 6'h10) begin
              if (wc == 16'd0) begin
                line_d = line_count + 16'd1;
              end else begin
                rem_d   = wc;
                state_d = PAYLOAD;
              end
            end
          end
        end else begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          hdr_d     = hdr_full;
        end
      end
      PAYLOAD: begin
        wr_d = 1'b1;
        if (!word_valid) begin
          // Burst died early: close the line downstream with an empty tlast beat.
          trunc_d   = 1'b1;
          wr_keep_d = '0;
          wr_last_d = 1'b1;
          state_d   = HDR;
        end else begin
          wr_user_d = sof_q;
          sof_d     = 1'b0;
          if (rem_q <= 16'(N_LANES)) begin
            wr_last_d = 1'b1;
            for (int k = 0; k < N_LANES; k++) wr_keep_d[k] = (16'(k) < rem_q);
            rem_d   = 16'd0;
            line_d  = line_count + 16'd1;
            state_d = WAIT_EOT;
          end else begin
            rem_d = rem_q - 16'(N_LANES);
          end
        end
      end
      WAIT_EOT: if (!word_valid) state_d = HDR;
      default:  state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HDR;
      hdr_cnt_q    <= 2'd0;
      hdr_q        <= 32'd0;
      rem_q        <= 16'd0;
      sof_q        <= 1'b0;
      frame_active <= 1'b0;
      line_count   <= 16'd0;
      truncated    <= 1'b0;
      wr_q         <= 1'b0;
      wr_entry_q   <= '0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      hdr_q        <= hdr_d;
      rem_q        <= rem_d;
      sof_q        <= sof_d;
      frame_active <= active_d;
      line_count   <= line_d;
      truncated    <= trunc_d;
      wr_q         <= wr_d;
      wr_entry_q   <= {wr_user_d, wr_last_d, wr_keep_d, word_in};
    end
  end

  // Output FIFO; count is kept apart from the wrapping pointers.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          pop, accept;

  assign m_axis_tvalid = (count_q != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign accept        = wr_q && ((count_q < CW'(FIFO_DEPTH)) || pop);
  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= wr_entry_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_q && !accept) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_csi_packet_rx.sv
// Bench for csi_packet_rx: a 2-lane/depth-4 instance and a 4-lane/depth-16 instance,
// packet table plus hand sequences, payload beats checked against a scoreboard queue.
module tb_csi_packet_rx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [15:0] word_a, td_a, lc_a;
  logic [1:0]  tk_a;
  logic wv_a, tv_a, tl_a, tu_a, tr_a, fa_a, ov_a, tc_a;
  logic [31:0] word_b, td_b;
  logic [15:0] lc_b;
  logic [3:0]  tk_b;
  logic wv_b, tv_b, tl_b, tu_b, tr_b, fa_b, ov_b, tc_b;

  csi_packet_rx #(.N_LANES(2), .FIFO_DEPTH(4), .VIRTUAL_CHANNEL(2'd0)) dut_a (
    .clk(clk), .reset(reset), .word_in(word_a), .word_valid(wv_a),
    .m_axis_tvalid(tv_a), .m_axis_tdata(td_a), .m_axis_tkeep(tk_a), .m_axis_tlast(tl_a),
    .m_axis_tuser(tu_a), .m_axis_tready(tr_a), .frame_active(fa_a), .line_count(lc_a),
    .overflow(ov_a), .truncated(tc_a));

  csi_packet_rx #(.N_LANES(4), .FIFO_DEPTH(16), .VIRTUAL_CHANNEL(2'd0)) dut_b (
    .clk(clk), .reset(reset), .word_in(word_b), .word_valid(wv_b),
    .m_axis_tvalid(tv_b), .m_axis_tdata(td_b), .m_axis_tkeep(tk_b), .m_axis_tlast(tl_b),
    .m_axis_tuser(tu_b), .m_axis_tready(tr_b), .frame_active(fa_b), .line_count(lc_b),
    .overflow(ov_b), .truncated(tc_b));

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    logic [7:0]  di;
    logic [15:0] wc;
    logic [7:0]  base;
    logic [15:0] exp_line;
    logic        exp_active;
  } vec_t;

  beat_t qa[$];
  beat_t qb[$];
  int n_vec = 0;
  int n_err = 0;
  bit sof_a = 1'b0;
  bit sof_b = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic check_beat(input int inst, input logic [31:0] d, input logic [3:0] k,
                            input logic l, input logic u);
    beat_t e;
    logic [31:0] m;
    n_vec++;
    if ((inst == 0 && qa.size() == 0) || (inst == 1 && qb.size() == 0)) begin
      n_err++;
      $display("FAIL beat%0d: unexpected beat data=%h keep=%b last=%b", inst, d, k, l);
      return;
    end
    if (inst == 0) e = qa.pop_front(); else e = qb.pop_front();
    m = 32'd0;
    for (int i = 0; i < 4; i++) if (e.keep[i]) m[8*i +: 8] = 8'hff;
    if ((d & m) !== e.data || k !== e.keep || l !== e.last || u !== e.user) begin
      n_err++;
      $display("FAIL beat%0d: got data=%h keep=%b last=%b user=%b, want data=%h keep=%b last=%b user=%b",
               inst, d & m, k, l, u, e.data, e.keep, e.last, e.user);
    end
  endtask

  always @(negedge clk) if (!reset && tv_a && tr_a) check_beat(0, {16'd0, td_a}, {2'b00, tk_a}, tl_a, tu_a);
  always @(negedge clk) if (!reset && tv_b && tr_b) check_beat(1, td_b, tk_b, tl_b, tu_b);

  // Drive one burst; trunc>=0 drops word_valid after that many payload beats,
  // push_max limits how many data beats are expected (the rest are overflow drops).
  task automatic send(input int inst, input logic [7:0] di, input logic [15:0] wc,
                      input logic [7:0] base, input int trunc, input int push_max);
    logic [7:0] bytes[$];
    int n, nb, wci, nbeats, limit, pushed, idx;
    bit s, lng;
    beat_t e;
    n   = (inst == 0) ? 2 : 4;
    wci = int'(wc);
    s   = (inst == 0) ? sof_a : sof_b;
    lng = (di[5:0] >= 6'h10);
    bytes.push_back(di); bytes.push_back(wc[7:0]); bytes.push_back(wc[15:8]); bytes.push_back(8'h00);
    if (lng && wci != 0) begin
      for (int i = 0; i < wci; i++) bytes.push_back(base + 8'(i));
      bytes.push_back(8'hC1); bytes.push_back(8'hC2);
    end
    while (bytes.size() % n != 0) bytes.push_back(8'h00);
    nb = bytes.size() / n;
    if (trunc >= 0) nb = 4 / n + trunc;
    if (di == 8'h00) s = 1'b1;
    if (lng && wci != 0 && di[7:6] == 2'b00) begin
      nbeats = (wci + n - 1) / n;
      limit  = (trunc >= 0) ? trunc : nbeats;
      pushed = 0;
      for (int b = 0; b < limit; b++) begin
        e.data = 32'd0; e.keep = 4'd0;
        for (int j = 0; j < n; j++) begin
          idx = b * n + j;
          if (idx < wci) begin
            e.data[8*j +: 8] = base + 8'(idx);
            e.keep[j] = 1'b1;
          end
        end
        e.last = (b == nbeats - 1);
        e.user = s;
        s = 1'b0;
        if (pushed < push_max) begin
          if (inst == 0) qa.push_back(e); else qb.push_back(e);
        end
        pushed++;
      end
      if (trunc >= 0) begin
        e.data = 32'd0; e.keep = 4'd0; e.last = 1'b1; e.user = 1'b0;
        if (inst == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
    if (inst == 0) sof_a = s; else sof_b = s;
    for (int b = 0; b < nb; b++) begin
      @(posedge clk); #1;
      if (inst == 0) begin
        word_a = {bytes[b*2+1], bytes[b*2]}; wv_a = 1'b1;
      end else begin
        word_b = {bytes[b*4+3], bytes[b*4+2], bytes[b*4+1], bytes[b*4]}; wv_b = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (inst == 0) wv_a = 1'b0; else wv_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int inst, input int budget);
    int c = 0;
    while (((inst == 0) ? qa.size() : qb.size()) != 0 && c < budget) begin
      @(posedge clk); c++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (((inst == 0) ? qa.size() : qb.size()) != 0) begin
      n_err++;
      $display("FAIL drain%0d: %0d beats still expected, want 0", inst, (inst == 0) ? qa.size() : qb.size());
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'h00, 16'd0, 8'h00, 16'd0, 1'b1};  // FS
    tbl[1] = '{8'h2A, 16'd6, 8'h01, 16'd1, 1'b1};  // line, 3 full beats
    tbl[2] = '{8'h6A, 16'd6, 8'h01, 16'd1, 1'b1};  // VC1: ignored
    tbl[3] = '{8'h2A, 16'd0, 8'h00, 16'd2, 1'b1};  // empty line
    tbl[4] = '{8'h05, 16'd9, 8'h00, 16'd2, 1'b1};  // other short: ignored
    tbl[5] = '{8'h2B, 16'd3, 8'h11, 16'd3, 1'b1};  // partial last beat
    tbl[6] = '{8'h01, 16'd0, 8'h00, 16'd3, 1'b0};  // FE
    tbl[7] = '{8'h40, 16'd0, 8'h00, 16'd3, 1'b0};  // FS on VC1: ignored

    reset = 1'b1; wv_a = 1'b0; wv_b = 1'b0; word_a = '0; word_b = '0; tr_a = 1'b1; tr_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, tv_a}, 32'd0);
    check("rst_line", {16'd0, lc_a}, 32'd0);
    check("rst_status", {29'd0, fa_a, ov_a, tc_a}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send(0, tbl[i].di, tbl[i].wc, tbl[i].base, -1, 99);
      drain(0, 50);
      check($sformatf("tbl%0d_line", i), {16'd0, lc_a}, {16'd0, tbl[i].exp_line});
      check($sformatf("tbl%0d_active", i), {31'd0, fa_a}, {31'd0, tbl[i].exp_active});
      check($sformatf("tbl%0d_sticky", i), {30'd0, ov_a, tc_a}, 32'd0);
    end

    // 4 lanes, WC=5: one full beat then a 1-byte tlast beat
    send(1, 8'h00, 16'd0, 8'h00, -1, 99);
    send(1, 8'h2A, 16'd5, 8'h0A, -1, 99);
    drain(1, 50);
    check("b_line", {16'd0, lc_b}, 32'd1);
    check("b_active", {31'd0, fa_b}, 32'd1);

    // truncated burst, then a clean packet
    send(0, 8'h00, 16'd0, 8'h00, -1, 99);
    send(0, 8'h2A, 16'd8, 8'h20, 2, 99);
    drain(0, 50);
    check("trunc_flag", {31'd0, tc_a}, 32'd1);
    check("trunc_line", {16'd0, lc_a}, 32'd0);
    send(0, 8'h2A, 16'd4, 8'h30, -1, 99);
    drain(0, 50);
    check("after_trunc_line", {16'd0, lc_a}, 32'd1);

    // overflow: 8 beats into a 4-deep FIFO with no ready
    tr_a = 1'b0;
    send(0, 8'h2A, 16'd16, 8'h40, -1, 4);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_flag", {31'd0, ov_a}, 32'd1);
    check("ovf_line", {16'd0, lc_a}, 32'd2);
    check("ovf_hold_valid", {31'd0, tv_a}, 32'd1);
    tr_a = 1'b1;
    drain(0, 50);

    // reset in PAYLOAD with FIFO holding data
    tr_a = 1'b0;
    @(posedge clk); #1; word_a = 16'h102A; wv_a = 1'b1;
    @(posedge clk); #1; word_a = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; word_a = {8'(2*i+1), 8'(2*i)};
    end
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_valid", {31'd0, tv_a}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_tvalid", {31'd0, tv_a}, 32'd0);
    check("mid_rst_status", {29'd0, fa_a, ov_a, tc_a}, 32'd0);
    check("mid_rst_line", {16'd0, lc_a}, 32'd0);
    qa.delete();
    sof_a = 1'b0;
    reset = 1'b0; wv_a = 1'b0; tr_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(0, 8'h00, 16'd0, 8'h00, -1, 99);
    send(0, 8'h2A, 16'd2, 8'h50, -1, 99);
    drain(0, 50);
    check("post_rst_line", {16'd0, lc_a}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    n_err++;
    $display("FAIL timeout: bench did not finish, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
